// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: buffers mono samples in a small FIFO and plays each
// one as a 64-BCLK frame, with the same truncated word in the left and right
// 32-bit slots. Data is MSB first with the standard one-BCLK delay after an
// LRCLK edge. Bit clock, word select and data all come from flops.
module i2s_tx_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 24,
  parameter int BCLK_DIV   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_valid,
  input  logic signed [DATA_WIDTH-1:0]  sample_in,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underrun
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  // Zero bits below the word inside a 32-bit slot vector.
  localparam int PAD   = 31 - OUT_WIDTH;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [5:0]           bit_cnt_q, bit_cnt_d;
  logic                 bclk_q,    bclk_d;
  logic                 lrclk_q,   lrclk_d;
  logic                 sdata_q,   sdata_d;
  logic [OUT_WIDTH-1:0] word_q,    word_d;

  logic [OUT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q,  rd_ptr_d;
  logic [LVL_W-1:0]     level_q,   level_d;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic                 bit_tick;
  logic                 frame_end;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 do_pop;
  logic                 do_push;
  logic [OUT_WIDTH-1:0] push_word;
  logic [31:0]          slot_bits;
  logic [4:0]           slot_pos;

  assign bit_tick   = (div_cnt_q == DIV_LAST);
  // The 63 -> 0 advance is where a new frame begins and the FIFO is read.
  assign frame_end  = bit_tick && (bit_cnt_q == 6'd63);
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_FULL);
  assign do_pop     = frame_end && !fifo_empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push    = sample_valid && (!fifo_full || do_pop);
  // Truncate to the transmitted width on entry; only these bits are ever sent.
  assign push_word  = sample_in[DATA_WIDTH-1 -: OUT_WIDTH];

  // Event pulses are reported in the cycle the event happens; reset masks
  // them because it discards whatever state produced them.
  assign overflow   = !reset && sample_valid && !do_push;
  assign underrun   = !reset && frame_end && fifo_empty;

  // The LSBs below the transmitted width are intentionally dropped.
  generate
    if (DATA_WIDTH > OUT_WIDTH) begin : g_lsb_sink
      logic unused_lsbs;
      assign unused_lsbs = ^sample_in[DATA_WIDTH-OUT_WIDTH-1:0];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic: divider, bit counter, word latch and the serial bit.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    bit_cnt_d = bit_cnt_q;
    word_d    = word_q;

    if (bit_tick) begin
      div_cnt_d = '0;
      bit_cnt_d = bit_cnt_q + 6'd1;
    end

    // The word is chosen once per frame; an empty FIFO yields a silent frame.
    if (frame_end) begin
      word_d = do_pop ? fifo_mem[rd_ptr_q] : '0;
    end

    bclk_d  = (div_cnt_d >= DIV_HALF);
    lrclk_d = bit_cnt_d[5];
  end

  // Serial bit for the upcoming slot position: slot bit s sits at position
  // 31-s of a 32-bit vector holding {0, word, padding zeros}, which gives the
  // one-BCLK MSB delay and zero padding without a range check.
  always_comb begin
    slot_pos  = bit_cnt_d[4:0];
    slot_bits = 32'(word_d) << PAD;
    sdata_d   = slot_bits[5'd31 - slot_pos];
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Timing and output registers; reset aborts any frame in progress and
  // restarts at bit 63 so the first tick after release begins a frame.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      bit_cnt_q <= 6'd63;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      word_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      word_q    <= word_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

  // Sample storage write port.
  // NOTE: the storage array is not reset; emptiness is tracked by the level and pointers alone.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      fifo_mem[wr_ptr_q] <= push_word;
    end
  end

  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer with BCLK_DIV=4, OUT_WIDTH=24,
// DATA_WIDTH=32, FIFO_DEPTH=4. Inputs change 1 time unit after the rising
// edge and outputs are sampled at the same point, so each sample reflects the
// state loaded by the edge just passed. Cycle 0 is the first cycle with reset
// low. Expected slots are hand-computed as {0, word[23:0], 7 zero bits}.
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [31:0] sample_in = '0;
  logic        bclk, lrclk, sdata;
  logic [2:0]  fifo_level;
  logic        overflow, underrun;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  i2s_tx_serializer #(
    .DATA_WIDTH (32),
    .OUT_WIDTH  (24),
    .BCLK_DIV   (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  // Samples and their hand-computed 32-bit slot patterns.
  logic [31:0] samp [5] = '{32'h123456AB, 32'hABCDEF01, 32'h00FF00FF,
                            32'hC0FFEE7F, 32'h80000055};
  logic [31:0] slot [5] = '{32'h091A2B00, 32'h55E6F780, 32'h007F8000,
                            32'h607FF700, 32'h40000000};

  localparam logic [63:0] LR_PATTERN = 64'h00000000_FFFFFFFF;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  // Hold reset over a few edges, check the reset values, release at cycle 0.
  task automatic do_reset(input string tag);
    sample_valid = 1'b0;
    reset = 1'b1;
    step();
    step();
    check({tag, "_rst_bclk"},  bclk,       1'b0);
    check({tag, "_rst_lrclk"}, lrclk,      1'b0);
    check({tag, "_rst_sdata"}, sdata,      1'b0);
    check({tag, "_rst_level"}, fifo_level, 3'd0);
    check({tag, "_rst_flags"}, {overflow, underrun}, 2'b00);
    reset = 1'b0;
    cyc = 0;
  endtask

  // Record one 64-bit frame, starting in the cycle that frame bit 0 appears.
  task automatic capture_frame(output logic [63:0] data, output logic [63:0] lr,
                               output int bclk_err, output int und_n,
                               output logic und_last);
    data = '0; lr = '0; bclk_err = 0; und_n = 0; und_last = 1'b0;
    for (int b = 0; b < 64; b++) begin
      for (int p = 0; p < 4; p++) begin
        if (bclk !== (p >= 2)) bclk_err++;
        if (p == 1) begin
          data[63-b] = sdata;
          lr[63-b]   = lrclk;
        end
        if (underrun === 1'b1) begin
          und_n++;
          if (b == 63 && p == 3) und_last = 1'b1;
        end
        step();
      end
    end
  endtask

  // Capture a frame and check data, word select, bit clock and the underrun
  // pulse (which may only appear on the frame's final tick).
  task automatic play_frame(input string tag, input logic [31:0] exp_slot,
                            input logic exp_und);
    logic [63:0] data, lr;
    int          bclk_err, und_n;
    logic        und_last;
    capture_frame(data, lr, bclk_err, und_n, und_last);
    check({tag, "_data"},     data,     {exp_slot, exp_slot});
    check({tag, "_lrclk"},    lr,       LR_PATTERN);
    check({tag, "_bclk_err"}, bclk_err, 0);
    check({tag, "_und_n"},    und_n,    exp_und ? 1 : 0);
    check({tag, "_und_last"}, und_last, exp_und);
  endtask

  // One sample pushed in cycle 0, played in frame 0; frame 1 underruns.
  task automatic single_sample(input string tag, input logic [31:0] s, input logic [31:0] exp_slot);
    do_reset(tag);
    sample_valid = 1'b1;
    sample_in    = s;
    check({tag, "_ovf"}, overflow, 1'b0);
    step();
    sample_valid = 1'b0;
    check({tag, "_lvl1"}, fifo_level, 3'd1);
    run_to(3);
    check({tag, "_und_c3"}, underrun, 1'b0);
    step();
    check({tag, "_lvl0"}, fifo_level, 3'd0);
    play_frame({tag, "_f0"}, exp_slot, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // No pushes: underrun at cycle 3 and every 256 cycles, silent frames.
    do_reset("idle");
    repeat (4) begin
      check($sformatf("idle_und_c%0d", cyc), underrun, cyc == 3);
      step();
    end
    play_frame("idle_f0", 32'h0, 1'b1);
    play_frame("idle_f1", 32'h0, 1'b1);

    // Positive full scale and negative full scale with discarded LSBs.
    single_sample("pos", 32'h7FFFFF00, 32'h3FFFFF80);
    single_sample("neg", 32'h80000055, 32'h40000000);

    // Five back-to-back pushes away from the pop tick: fifth is dropped.
    do_reset("burst");
    run_to(4);
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1;
      sample_in    = samp[i];
      check($sformatf("burst_ovf%0d", i), overflow, i == 4);
      step();
      check($sformatf("burst_lvl%0d", i), fifo_level, (i < 4) ? i + 1 : 4);
    end
    sample_valid = 1'b0;
    run_to(259);
    check("burst_und_c259", underrun, 1'b0);
    step();
    check("burst_lvl_after_pop", fifo_level, 3'd3);
    for (int i = 0; i < 4; i++)
      play_frame($sformatf("burst_f%0d", i + 1), slot[i], i == 3);
    play_frame("burst_f5", 32'h0, 1'b1);

    // Full FIFO, push coincident with the 63->0 pop: accepted, level holds.
    do_reset("fullpp");
    run_to(4);
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1;
      sample_in    = samp[i];
      step();
    end
    sample_valid = 1'b0;
    check("fullpp_lvl_full", fifo_level, 3'd4);
    run_to(259);
    sample_valid = 1'b1;
    sample_in    = samp[4];
    check("fullpp_ovf", overflow, 1'b0);
    check("fullpp_und", underrun, 1'b0);
    step();
    sample_valid = 1'b0;
    check("fullpp_lvl", fifo_level, 3'd4);
    for (int i = 0; i < 5; i++)
      play_frame($sformatf("fullpp_f%0d", i + 1), slot[i], i == 4);

    // Empty FIFO, push coincident with the pop tick: no bypass, stored.
    do_reset("emptypp");
    run_to(3);
    sample_valid = 1'b1;
    sample_in    = 32'h7FFFFF00;
    check("emptypp_und", underrun, 1'b1);
    check("emptypp_ovf", overflow, 1'b0);
    step();
    sample_valid = 1'b0;
    check("emptypp_lvl", fifo_level, 3'd1);
    play_frame("emptypp_f0", 32'h0, 1'b0);
    play_frame("emptypp_f1", 32'h3FFFFF80, 1'b1);

    // One-cycle reset at frame bit 40 discards the frame and the FIFO.
    do_reset("midrst");
    sample_valid = 1'b1;
    sample_in    = samp[0];
    step();
    sample_valid = 1'b0;
    run_to(5);
    sample_valid = 1'b1;
    sample_in    = samp[1];
    step();
    sample_valid = 1'b0;
    run_to(165);
    check("midrst_pre_lrclk", lrclk, 1'b1);
    check("midrst_pre_lvl", fifo_level, 3'd1);
    reset = 1'b1;
    step();
    check("midrst_bclk",  bclk,       1'b0);
    check("midrst_lrclk", lrclk,      1'b0);
    check("midrst_sdata", sdata,      1'b0);
    check("midrst_lvl",   fifo_level, 3'd0);
    check("midrst_flags", {overflow, underrun}, 2'b00);
    reset = 1'b0;
    cyc = 0;
    repeat (4) begin
      check($sformatf("midrst_und_c%0d", cyc), underrun, cyc == 3);
      step();
    end
    play_frame("midrst_f0", 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
